// File: rtl/fxp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mult_arbiter
// Purpose  : Round-robin arbiter that shares one signed Q8.7 fixed-point
//            multiplier (16-bit, 7 fractional bits, round-half-up) among
//            N_REQ requesters. The result comes back tagged with the
//            requester index two cycles after the accept. Per-requester
//            sticky overflow flags feed the solver status registers.
// Ports    :
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_req_valid   [N_REQ]     request pending, one bit per requester
//   i_req_a       [16*N_REQ]  multiplicands, lane i = [16i+15:16i], signed
//   i_req_b       [16*N_REQ]  multipliers, same packing
//   o_req_ready   [N_REQ]     one-hot grant (combinational)
//   o_rsp_valid               result valid this cycle (one-cycle pulse)
//   o_rsp_id      [ID_W]      requester index owning the result
//   o_rsp_data    [16]        signed product, 7 fractional bits
//   o_rsp_ovf                 overflow flag for this result
//   o_ovf_sticky  [N_REQ]     per-requester sticky overflow
//   i_ovf_clr     [N_REQ]     per-requester sticky clear strobe
// Revision : 1.0 - initial release
// ============================================================================
module fxp_mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [16*N_REQ-1:0]  i_req_a,
   input  logic [16*N_REQ-1:0]  i_req_b,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic                 o_rsp_valid,
   output logic [ID_W-1:0]      o_rsp_id,
   output logic [15:0]          o_rsp_data,
   output logic                 o_rsp_ovf,
   output logic [N_REQ-1:0]     o_ovf_sticky,
   input  logic [N_REQ-1:0]     i_ovf_clr
);

   // Half an LSB of the Q.7 result, added before truncation.
   localparam logic signed [31:0] c_ROUND = 32'sd64;

   // ------------------------------------------------------------------------
   // Round-robin arbitration
   // ------------------------------------------------------------------------
   logic [ID_W-1:0]     r_rr_ptr;
   logic                w_grant;
   logic [ID_W-1:0]     w_grant_idx;
   logic [ID_W-1:0]     w_cand_id;
   int                  w_cand;
   logic [ID_W-1:0]     w_next_ptr;
   logic [15:0]         w_a;
   logic [15:0]         w_b;

   // Scan from the highest offset down so the candidate closest to the
   // pointer (offset 0) is the last one written and therefore wins.
   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
      w_cand      = 0;
      w_cand_id   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand    = (int'(r_rr_ptr) + k) % N_REQ;
         w_cand_id = w_cand[ID_W-1:0];
         if (i_req_valid[w_cand_id]) begin
            w_grant     = 1'b1;
            w_grant_idx = w_cand_id;
         end
      end
   end

   assign o_req_ready = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_grant_idx)
                                : '0;

   // Explicit wrap so non-power-of-two N_REQ works.
   assign w_next_ptr = (int'(w_grant_idx) == N_REQ - 1) ? '0
                                                         : w_grant_idx + ID_W'(1);

   assign w_a = i_req_a[16*w_grant_idx +: 16];
   assign w_b = i_req_b[16*w_grant_idx +: 16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         r_rr_ptr <= w_next_ptr;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1: operand registers
   // ------------------------------------------------------------------------
   logic                r_s1_valid;
   logic signed [15:0]  r_s1_a;
   logic signed [15:0]  r_s1_b;
   logic [ID_W-1:0]     r_s1_id;

   // Operands only load on an accept; they are don't-care when s1 is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
      end else begin
         r_s1_valid <= w_grant;
         if (w_grant) begin
            r_s1_a  <= w_a;
            r_s1_b  <= w_b;
            r_s1_id <= w_grant_idx;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: multiply, round, flag overflow, register response
   // ------------------------------------------------------------------------
   logic signed [31:0]  w_prod;
   logic signed [31:0]  w_full;
   logic                w_ovf;

   assign w_prod = 32'(r_s1_a) * 32'(r_s1_b);
   assign w_full = w_prod + c_ROUND;
   // Result fits in 16 bits only if bits 31..22 are a pure sign extension.
   assign w_ovf  = ~((w_full[31:22] == 10'h000) | (w_full[31:22] == 10'h3FF));

   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [15:0]         r_rsp_data;
   logic                r_rsp_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_ovf   <= 1'b0;
      end else begin
         r_rsp_valid <= r_s1_valid;
         r_rsp_id    <= r_s1_id;
         r_rsp_data  <= w_full[22:7];
         r_rsp_ovf   <= w_ovf;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_ovf   = r_rsp_ovf;

   // ------------------------------------------------------------------------
   // Sticky overflow flags, set from the registered response (so they rise
   // one cycle after the flagged result). Set wins over a same-cycle clear.
   // ------------------------------------------------------------------------
   logic [N_REQ-1:0]    r_ovf_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_sticky <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (r_rsp_valid && r_rsp_ovf && (int'(r_rsp_id) == i)) begin
               r_ovf_sticky[i] <= 1'b1;
            end else if (i_ovf_clr[i]) begin
               r_ovf_sticky[i] <= 1'b0;
            end
         end
      end
   end

   assign o_ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire
